// File: rtl/multi_button_debouncer.sv
// N-channel button conditioner: two-flop synchroniser, symmetric stable-count debounce,
// rise/fall/press pulses with optional auto-repeat, and a lowest-index press reporter.
module multi_button_debouncer #(
   parameter int CHANNELS             = 4,
   parameter int DEBOUNCE_CYCLES      = 1000000,
   parameter int REPEAT_EN            = 1,
   parameter int REPEAT_DELAY_CYCLES  = 50000000,
   parameter int REPEAT_PERIOD_CYCLES = 10000000,
   localparam int EW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] pin,
   output logic [CHANNELS-1:0] level,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic [CHANNELS-1:0] press,
   output logic                event_valid,
   output logic [EW-1:0]       event_ch
);

   localparam int CW = (DEBOUNCE_CYCLES > 1)      ? $clog2(DEBOUNCE_CYCLES)      : 1;
   localparam int DW = (REPEAT_DELAY_CYCLES > 1)  ? $clog2(REPEAT_DELAY_CYCLES)  : 1;
   localparam int PW = (REPEAT_PERIOD_CYCLES > 1) ? $clog2(REPEAT_PERIOD_CYCLES) : 1;
   localparam int RW = (DW > PW) ? DW : PW;

   localparam logic [CW-1:0] CNT_LAST    = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY_CYCLES - 1);
   localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD_CYCLES - 1);

   typedef enum logic [1:0] {RELEASED, DELAY, REPEAT} rep_state_t;

   logic [EW-1:0] first_ch;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      logic          sync_a, sync_b;
      logic          level_q, rise_q, fall_q, press_q;
      logic [CW-1:0] cnt;
      logic [RW-1:0] rcnt;
      rep_state_t    state;
      logic          settle, rise_evt, fall_evt;

      // NOTE: settle is decoded from the current count so that level, rise/fall and
      // press all update on the same edge; registering it would add a cycle of skew.
      assign settle   = (sync_b != level_q) && (cnt == CNT_LAST);
      assign rise_evt = settle && sync_b;
      assign fall_evt = settle && !sync_b;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            sync_a  <= 1'b0;
            sync_b  <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            press_q <= 1'b0;
            cnt     <= '0;
            rcnt    <= '0;
            state   <= RELEASED;
         end else begin
            sync_a  <= pin[g];
            sync_b  <= sync_a;
            rise_q  <= rise_evt;
            fall_q  <= fall_evt;
            press_q <= 1'b0;

            if ((sync_b == level_q) || settle) cnt <= '0;
            else                               cnt <= cnt + 1'b1;
            if (settle) level_q <= sync_b;

            // A fall is tested before the terminal count so it suppresses a coincident repeat.
            case (state)
               RELEASED: begin
                  if (rise_evt) begin
                     press_q <= 1'b1;
                     rcnt    <= '0;
                     if (REPEAT_EN != 0) state <= DELAY;
                  end
               end
               DELAY: begin
                  if (fall_evt) begin
                     state <= RELEASED;
                     rcnt  <= '0;
                  end else if (rcnt == DELAY_LAST) begin
                     press_q <= 1'b1;
                     rcnt    <= '0;
                     state   <= REPEAT;
                  end else begin
                     rcnt <= rcnt + 1'b1;
                  end
               end
               REPEAT: begin
                  if (fall_evt) begin
                     state <= RELEASED;
                     rcnt  <= '0;
                  end else if (rcnt == PERIOD_LAST) begin
                     press_q <= 1'b1;
                     rcnt    <= '0;
                  end else begin
                     rcnt <= rcnt + 1'b1;
                  end
               end
               default: begin
                  state <= RELEASED;
                  rcnt  <= '0;
               end
            endcase
         end
      end

      assign level[g] = level_q;
      assign rise[g]  = rise_q;
      assign fall[g]  = fall_q;
      assign press[g] = press_q;
   end

   always_comb begin
      first_ch = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (press[i]) first_ch = EW'(i);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         event_valid <= 1'b0;
         event_ch    <= '0;
      end else begin
         event_valid <= |press;
         event_ch    <= first_ch;
      end
   end

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Bench for multi_button_debouncer: a repeating and a non-repeating instance share one pin
// bus and are compared every cycle against a timestamp-based reference model.
module tb_multi_button_debouncer;

   localparam int CH  = 4;
   localparam int DB  = 4;
   localparam int DLY = 20;
   localparam int PER = 8;
   localparam int EW  = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [CH-1:0] pin = '0;

   logic [CH-1:0] level, rise, fall, press;
   logic          event_valid;
   logic [EW-1:0] event_ch;
   logic [CH-1:0] nr_level, nr_rise, nr_fall, nr_press;
   logic          nr_event_valid;
   logic [EW-1:0] nr_event_ch;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   multi_button_debouncer #(
      .CHANNELS(CH), .DEBOUNCE_CYCLES(DB), .REPEAT_EN(1),
      .REPEAT_DELAY_CYCLES(DLY), .REPEAT_PERIOD_CYCLES(PER)
   ) dut (
      .clk(clk), .rst(rst), .pin(pin),
      .level(level), .rise(rise), .fall(fall), .press(press),
      .event_valid(event_valid), .event_ch(event_ch)
   );

   multi_button_debouncer #(
      .CHANNELS(CH), .DEBOUNCE_CYCLES(DB), .REPEAT_EN(0),
      .REPEAT_DELAY_CYCLES(DLY), .REPEAT_PERIOD_CYCLES(PER)
   ) dut_norep (
      .clk(clk), .rst(rst), .pin(pin),
      .level(nr_level), .rise(nr_rise), .fall(nr_fall), .press(nr_press),
      .event_valid(nr_event_valid), .event_ch(nr_event_ch)
   );

   // Reference model: level follows the synchronised pin once it has disagreed with level
   // for DB edges since the later of the last agreement and the last change; repeats are
   // pure arithmetic on the time since the last rise.
   logic [CH-1:0] pin_hist [$];
   logic [CH-1:0] m_seen;
   int            edge_no;
   int            last_same [CH];
   int            last_change [CH];
   int            last_rise [CH];
   logic [CH-1:0] exp_level, exp_rise, exp_fall, exp_press_a, exp_press_b;
   logic          exp_ev_a, exp_ev_b;
   logic [EW-1:0] exp_ch_a, exp_ch_b;

   function automatic logic [EW-1:0] lowest(input logic [CH-1:0] v);
      for (int i = 0; i < CH; i++) if (v[i]) return EW'(i);
      return '0;
   endfunction

   task automatic model_clear();
      edge_no = 0;
      pin_hist.delete();
      pin_hist.push_back('0);
      pin_hist.push_back('0);
      exp_level = '0; exp_rise = '0; exp_fall = '0;
      exp_press_a = '0; exp_press_b = '0;
      exp_ev_a = 1'b0; exp_ev_b = 1'b0; exp_ch_a = '0; exp_ch_b = '0;
      for (int c = 0; c < CH; c++) begin
         last_same[c] = 0; last_change[c] = 0; last_rise[c] = 0;
      end
   endtask

   initial begin
      model_clear();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            model_clear();
         end else begin
            edge_no++;
            m_seen = pin_hist.pop_front();
            pin_hist.push_back(pin);
            exp_ev_a = |exp_press_a; exp_ch_a = lowest(exp_press_a);
            exp_ev_b = |exp_press_b; exp_ch_b = lowest(exp_press_b);
            exp_rise = '0; exp_fall = '0;
            for (int c = 0; c < CH; c++) begin
               if (m_seen[c] == exp_level[c]) begin
                  last_same[c] = edge_no;
               end else if (edge_no - ((last_same[c] > last_change[c]) ? last_same[c] : last_change[c]) >= DB) begin
                  exp_level[c]   = m_seen[c];
                  last_change[c] = edge_no;
                  if (m_seen[c]) begin
                     exp_rise[c]  = 1'b1;
                     last_rise[c] = edge_no;
                  end else begin
                     exp_fall[c] = 1'b1;
                  end
               end
            end
            exp_press_b = exp_rise;
            for (int c = 0; c < CH; c++) begin
               exp_press_a[c] = exp_rise[c] ||
                  (exp_level[c] && (edge_no - last_rise[c] >= DLY) &&
                   ((edge_no - last_rise[c] - DLY) % PER == 0));
            end
         end
      end
   end

   logic [37:0] obs, exp_all;
   assign obs     = {level, rise, fall, press, event_valid, event_ch,
                     nr_level, nr_rise, nr_fall, nr_press, nr_event_valid, nr_event_ch};
   assign exp_all = {exp_level, exp_rise, exp_fall, exp_press_a, exp_ev_a, exp_ch_a,
                     exp_level, exp_rise, exp_fall, exp_press_b, exp_ev_b, exp_ch_b};

   task automatic test_reset();
      int rise_at = -1;
      pin = '1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (obs !== '0) begin
         n_errors++; $display("FAIL reset_state: got %h, want 0", obs);
      end
      rst = 1'b0;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== exp_all) begin
            n_errors++; $display("FAIL reset_release n=%0d: got %h, want %h", n, obs, exp_all);
         end
         if (rise_at < 0 && rise == 4'b1111) rise_at = n;
      end
      n_checks++;
      if (rise_at != DB + 2) begin
         n_errors++; $display("FAIL reset_rise_latency: got %0d, want %0d", rise_at, DB + 2);
      end
      pin = '0;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== exp_all) begin
            n_errors++; $display("FAIL reset_settle n=%0d: got %h, want %h", n, obs, exp_all);
         end
      end
   endtask

   task automatic test_clean_press();
      int t_rise = -1, t_rep1 = -1, t_rep2 = -1, n_press = 0;
      pin[0] = 1'b1;
      for (int n = 1; n <= 100; n++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== exp_all) begin
            n_errors++; $display("FAIL clean_press n=%0d: got %h, want %h", n, obs, exp_all);
         end
         if (press[0]) begin
            n_press++;
            if (n_press == 1) t_rise = n;
            else if (n_press == 2) t_rep1 = n;
            else if (n_press == 3) t_rep2 = n;
         end
      end
      n_checks++;
      if (t_rise != DB + 2) begin
         n_errors++; $display("FAIL clean_rise_latency: got %0d, want %0d", t_rise, DB + 2);
      end
      n_checks++;
      if (t_rep1 - t_rise != DLY) begin
         n_errors++; $display("FAIL clean_first_repeat: got %0d, want %0d", t_rep1 - t_rise, DLY);
      end
      n_checks++;
      if (t_rep2 - t_rep1 != PER) begin
         n_errors++; $display("FAIL clean_repeat_period: got %0d, want %0d", t_rep2 - t_rep1, PER);
      end
      n_checks++;
      if (n_press != 11) begin
         n_errors++; $display("FAIL clean_press_count: got %0d, want 11", n_press);
      end
      pin[0] = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== exp_all) begin
            n_errors++; $display("FAIL clean_release n=%0d: got %h, want %h", n, obs, exp_all);
         end
      end
   endtask

   task automatic test_bounce();
      int pulses = 0;
      int low_len;
      for (int b = 0; b < 10; b++) begin
         pin[1] = 1'b1;
         for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== exp_all) begin
               n_errors++; $display("FAIL bounce_high b=%0d: got %h, want %h", b, obs, exp_all);
            end
            if ((rise | fall | press) != '0) pulses++;
         end
         pin[1] = 1'b0;
         low_len = $urandom_range(1, 3);
         for (int n = 0; n < low_len; n++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== exp_all) begin
               n_errors++; $display("FAIL bounce_low b=%0d: got %h, want %h", b, obs, exp_all);
            end
            if ((rise | fall | press) != '0) pulses++;
         end
      end
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if ((rise | fall | press) != '0) pulses++;
      end
      n_checks++;
      if (pulses != 0 || level[1] !== 1'b0) begin
         n_errors++; $display("FAIL bounce_reject: pulses %0d level %b, want 0 and 0", pulses, level[1]);
      end
   endtask

   task automatic test_release_during_delay();
      bit found = 0;
      int n_press = 0, fall_at = -1;
      pin[2] = 1'b1;
      for (int n = 0; n < 20 && !found; n++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== exp_all) begin
            n_errors++; $display("FAIL release_wait n=%0d: got %h, want %h", n, obs, exp_all);
         end
         if (rise[2]) begin found = 1; n_press++; end
      end
      n_checks++;
      if (!found) begin
         n_errors++; $display("FAIL release_rise_timeout: got no rise, want rise within 20");
      end
      for (int n = 0; n < 14; n++) begin
         @(negedge clk);
         if (press[2]) n_press++;
      end
      pin[2] = 1'b0;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== exp_all) begin
            n_errors++; $display("FAIL release_low n=%0d: got %h, want %h", n, obs, exp_all);
         end
         if (press[2]) n_press++;
         if (fall[2] && fall_at < 0) fall_at = n;
      end
      n_checks++;
      if (n_press != 1) begin
         n_errors++; $display("FAIL release_press_count: got %0d, want 1", n_press);
      end
      n_checks++;
      if (fall_at != DB + 2) begin
         n_errors++; $display("FAIL release_fall_time: got %0d, want %0d", fall_at, DB + 2);
      end
   endtask

   task automatic test_simultaneous();
      bit found = 0;
      int skew = 0;
      pin[1] = 1'b1;
      pin[3] = 1'b1;
      for (int n = 0; n < 20 && !found; n++) begin
         @(negedge clk);
         if (press != '0) found = 1;
      end
      n_checks++;
      if (press !== 4'b1010) begin
         n_errors++; $display("FAIL simul_press: got %b, want 1010", press);
      end
      @(negedge clk);
      n_checks++;
      if ({event_valid, event_ch} !== 3'b101) begin
         n_errors++; $display("FAIL simul_event: got valid %b ch %0d, want valid 1 ch 1", event_valid, event_ch);
      end
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== exp_all) begin
            n_errors++; $display("FAIL simul_hold n=%0d: got %h, want %h", n, obs, exp_all);
         end
         if (press[1] != press[3]) skew++;
      end
      n_checks++;
      if (skew != 0) begin
         n_errors++; $display("FAIL simul_lockstep: got %0d skewed cycles, want 0", skew);
      end
      pin[1] = 1'b0;
      pin[3] = 1'b0;
      repeat (15) @(negedge clk);
   endtask

   task automatic test_reset_mid_repeat();
      bit found = 0;
      int rise_at = -1, rep_at = -1, n_press = 0;
      pin[0] = 1'b1;
      for (int n = 0; n < 20 && !found; n++) begin
         @(negedge clk);
         if (rise[0]) found = 1;
      end
      for (int n = 0; n < 24; n++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== exp_all) begin
            n_errors++; $display("FAIL midrst_hold n=%0d: got %h, want %h", n, obs, exp_all);
         end
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (obs !== '0) begin
         n_errors++; $display("FAIL midrst_async_clear: got %h, want 0", obs);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== exp_all) begin
            n_errors++; $display("FAIL midrst_after n=%0d: got %h, want %h", n, obs, exp_all);
         end
         if (rise[0] && rise_at < 0) rise_at = n;
         if (press[0]) begin
            n_press++;
            if (n_press == 2) rep_at = n;
         end
      end
      n_checks++;
      if (rise_at != DB + 2) begin
         n_errors++; $display("FAIL midrst_rise_latency: got %0d, want %0d", rise_at, DB + 2);
      end
      n_checks++;
      if (rep_at - rise_at != DLY) begin
         n_errors++; $display("FAIL midrst_first_repeat: got %0d, want %0d", rep_at - rise_at, DLY);
      end
      pin[0] = 1'b0;
      repeat (15) @(negedge clk);
   endtask

   task automatic test_no_repeat();
      int n_press = 0, differ = 0;
      pin[0] = 1'b1;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== exp_all) begin
            n_errors++; $display("FAIL norep_hold n=%0d: got %h, want %h", n, obs, exp_all);
         end
         if (nr_press[0]) n_press++;
         if (nr_press !== nr_rise) differ++;
      end
      n_checks++;
      if (n_press != 1) begin
         n_errors++; $display("FAIL norep_press_count: got %0d, want 1", n_press);
      end
      n_checks++;
      if (differ != 0) begin
         n_errors++; $display("FAIL norep_press_is_rise: got %0d differing cycles, want 0", differ);
      end
      pin[0] = 1'b0;
      repeat (15) @(negedge clk);
   endtask

   task automatic test_random();
      int hold [CH];
      for (int c = 0; c < CH; c++) hold[c] = 0;
      for (int n = 0; n < 3000; n++) begin
         for (int c = 0; c < CH; c++) begin
            if (hold[c] == 0) begin
               pin[c]  = ~pin[c];
               hold[c] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 60);
            end else begin
               hold[c]--;
            end
         end
         @(negedge clk);
         n_checks++;
         if (obs !== exp_all) begin
            n_errors++; $display("FAIL random n=%0d pin=%b: got %h, want %h", n, pin, obs, exp_all);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_release_during_delay();
      test_simultaneous();
      test_reset_mid_repeat();
      test_no_repeat();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
